// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one external combinational adder among NREQ requesters,
// with chain lock for multi-word adds. Define ADDER_ARB_OVF_EN to add the rsp_ovf output.
module adder_share_arbiter #(
    parameter int W    = 8,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    input  logic [NREQ-1:0]   req_chain,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    output logic              add_cin,
    input  logic [W-1:0]      add_s,
    input  logic              add_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_last
`ifdef ADDER_ARB_OVF_EN
    ,
    output logic              rsp_ovf
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         r_state;
    logic [IDW-1:0] r_rr_ptr;
    logic           r_lock;
    logic           r_carry_q;
    logic [IDW-1:0] r_id;
    logic           r_chain;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_grant_id;
    logic            w_found;
    logic [IDW:0]    w_cand;
    logic [IDW-1:0]  w_rr_next;

    // Handshake: a request transfers on a rising edge where req_valid[i] & req_ready[i];
    // a response transfers on a rising edge where rsp_valid & rsp_ready.
    // While locked, r_id still names the chain owner because nobody else can be accepted.
    always_comb begin
        w_grant    = '0;
        w_grant_id = '0;
        w_found    = 1'b0;
        w_cand     = '0;
        if (r_state == S_IDLE) begin
            if (r_lock) begin
                if (req_valid[r_id]) begin
                    w_grant[r_id] = 1'b1;
                    w_grant_id    = r_id;
                end
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    w_cand = {1'b0, r_rr_ptr} + (IDW+1)'(k);
                    if (w_cand >= (IDW+1)'(NREQ)) begin
                        w_cand = w_cand - (IDW+1)'(NREQ);
                    end
                    if (!w_found && req_valid[w_cand[IDW-1:0]]) begin
                        w_found                    = 1'b1;
                        w_grant[w_cand[IDW-1:0]]   = 1'b1;
                        w_grant_id                 = w_cand[IDW-1:0];
                    end
                end
            end
        end
    end

    assign w_rr_next = (r_id == IDW'(NREQ-1)) ? '0 : r_id + 1'b1;

    // Gated so the grant reads zero for the whole time reset is asserted.
    assign req_ready = rst_n ? w_grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_lock    <= 1'b0;
            r_carry_q <= 1'b0;
            r_id      <= '0;
            r_chain   <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
            rsp_last  <= 1'b0;
`ifdef ADDER_ARB_OVF_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_grant) begin
                        add_a   <= req_a[w_grant_id*W +: W];
                        add_b   <= req_b[w_grant_id*W +: W];
                        add_cin <= r_lock ? r_carry_q : req_cin[w_grant_id];
                        r_id    <= w_grant_id;
                        r_chain <= req_chain[w_grant_id];
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    rsp_sum   <= add_s;
                    rsp_cout  <= add_cout;
                    r_carry_q <= add_cout;
                    rsp_id    <= r_id;
                    rsp_last  <= ~r_chain;
                    rsp_valid <= 1'b1;
`ifdef ADDER_ARB_OVF_EN
                    rsp_ovf   <= (add_a[W-1] == add_b[W-1]) && (add_s[W-1] != add_a[W-1]);
`endif
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                        if (r_chain) begin
                            r_lock <= 1'b1;
                        end else begin
                            r_lock   <= 1'b0;
                            r_rr_ptr <= w_rr_next;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: directed vectors push expected responses,
// a negedge monitor pops and compares on every response transfer.
module tb_adder_share_arbiter;

    localparam int W    = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ-1:0]   req_chain;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic              add_cin;
    logic [W-1:0]      add_s;
    logic              add_cout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_last;
`ifdef ADDER_ARB_OVF_EN
    logic              rsp_ovf;
`endif

    int checks   = 0;
    int failures = 0;

    // entry = {id[1:0], sum[7:0], cout, last, ovf}
    logic [12:0] exp_q[$];

    adder_share_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_chain (req_chain),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
        .rsp_last  (rsp_last)
`ifdef ADDER_ARB_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    // External combinational adder
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    // ---------------- clock/reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [7:0] sum, input logic cout,
                            input logic last, input logic ovf);
        exp_q.push_back({id, sum, cout, last, ovf});
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic chain);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = cin;
        req_chain[i]    = chain;
        req_valid[i]    = 1'b1;
    endtask

    // Waits for requester i to be granted, checks the grant is exactly one-hot on i,
    // returns 1 time unit after the accepting edge.
    task automatic wait_grant(input int i, input logic keep_valid);
        int n;
        logic [NREQ-1:0] exp_g;
        n = 0;
        exp_g = '0;
        exp_g[i] = 1'b1;
        @(negedge clk);
        while (!req_ready[i] && n < 60) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("grant_%0d", i), 32'(req_ready), 32'(exp_g));
        @(posedge clk);
        #1;
        if (!keep_valid) req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_add"}, {15'd0, add_cin, add_a, add_b}, 32'd0);
        check({tag, "_rsp"}, {19'd0, rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last}, 32'd0);
`ifdef ADDER_ARB_OVF_EN
        check({tag, "_ovf"}, 32'(rsp_ovf), 32'd0);
`endif
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            logic [12:0] e;
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {19'd0, rsp_id, rsp_sum, rsp_cout, rsp_last, 1'b0}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_fields", {20'd0, rsp_id, rsp_sum, rsp_cout, rsp_last},
                      {20'd0, e[12:1]});
`ifdef ADDER_ARB_OVF_EN
                check("rsp_ovf", 32'(rsp_ovf), 32'(e[0]));
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_chain = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        req_valid = '0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;

        // Round robin: all four valid continuously -> 0,1,2,3,0
        set_req(0, 8'h01, 8'h10, 1'b0, 1'b0);
        set_req(1, 8'h12, 8'h10, 1'b0, 1'b0);
        set_req(2, 8'h23, 8'h10, 1'b0, 1'b0);
        set_req(3, 8'h34, 8'h10, 1'b0, 1'b0);
        push_exp(2'd0, 8'h11, 1'b0, 1'b1, 1'b0);
        push_exp(2'd1, 8'h22, 1'b0, 1'b1, 1'b0);
        push_exp(2'd2, 8'h33, 1'b0, 1'b1, 1'b0);
        push_exp(2'd3, 8'h44, 1'b0, 1'b1, 1'b0);
        push_exp(2'd0, 8'h11, 1'b0, 1'b1, 1'b0);
        wait_grant(0, 1'b1);
        wait_grant(1, 1'b1);
        wait_grant(2, 1'b1);
        wait_grant(3, 1'b1);
        wait_grant(0, 1'b1);
        req_valid = '0;
        drain();

        // Single op with latency check
        set_req(0, 8'h3C, 8'h44, 1'b0, 1'b0);
        push_exp(2'd0, 8'h80, 1'b0, 1'b1, 1'b1);
        wait_grant(0, 1'b0);
        @(negedge clk);
        check("lat_calc_not_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(rsp_valid), 32'd1);
        drain();

        // Carry and overflow on requester 2
        set_req(2, 8'hFF, 8'h01, 1'b1, 1'b0);
        push_exp(2'd2, 8'h01, 1'b1, 1'b1, 1'b0);
        wait_grant(2, 1'b0);
        drain();
        set_req(2, 8'h7F, 8'h01, 1'b0, 1'b0);
        push_exp(2'd2, 8'h80, 1'b0, 1'b1, 1'b1);
        wait_grant(2, 1'b0);
        drain();

        // Chain on requester 1 while requester 3 waits
        set_req(1, 8'hFF, 8'h01, 1'b0, 1'b1);
        push_exp(2'd1, 8'h00, 1'b1, 1'b0, 1'b0);
        wait_grant(1, 1'b0);
        set_req(3, 8'h05, 8'h06, 1'b0, 1'b0);
        drain();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("lock_block", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        set_req(1, 8'h00, 8'h00, 1'b0, 1'b0);
        push_exp(2'd1, 8'h01, 1'b0, 1'b1, 1'b0);
        push_exp(2'd3, 8'h0B, 1'b0, 1'b1, 1'b0);
        wait_grant(1, 1'b0);
        wait_grant(3, 1'b0);
        drain();

        // Back-pressure: hold response for 5 cycles
        rsp_ready = 1'b0;
        set_req(0, 8'h12, 8'h34, 1'b0, 1'b0);
        push_exp(2'd0, 8'h46, 1'b0, 1'b1, 1'b0);
        wait_grant(0, 1'b0);
        set_req(1, 8'h20, 8'h22, 1'b0, 1'b0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold", {20'd0, rsp_valid, rsp_sum, rsp_id, req_ready},
                  {20'd0, 1'b1, 8'h46, 2'd0, 4'b0000});
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        push_exp(2'd1, 8'h42, 1'b0, 1'b1, 1'b0);
        wait_grant(1, 1'b0);
        drain();

        // Reset mid-CALC: no response may follow
        set_req(0, 8'h01, 8'h02, 1'b0, 1'b0);
        wait_grant(0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_calc");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-chain: lock on requester 2 must be dropped
        set_req(2, 8'hFF, 8'hFF, 1'b0, 1'b1);
        push_exp(2'd2, 8'hFE, 1'b1, 1'b0, 1'b0);
        wait_grant(2, 1'b0);
        drain();
        set_req(0, 8'h03, 8'h04, 1'b0, 1'b0);
        set_req(2, 8'h01, 8'h01, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_chain");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp(2'd0, 8'h07, 1'b0, 1'b1, 1'b0);
        push_exp(2'd2, 8'h02, 1'b0, 1'b1, 1'b0);
        wait_grant(0, 1'b0);
        wait_grant(2, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
